// File: rtl/n64_vdemux.sv
// n64_vdemux: front-end demultiplexer for the N64 digital video bus.
//
// The N64 drives a 7-bit bus that carries one pixel over four VCLK cycles:
// sync bits (D_i[3:0], marked by nDSYNC low), then R, G and B. This block
// registers the bus, follows the phase of that cadence, reassembles a
// {sync, R, G, B} vector and presents it with a one-cycle valid strobe.
// A lock FSM requires LOCK_CNT consecutive 4-cycle periods before any pixel
// is passed downstream, and drops lock on the first cadence violation.
//
// Ports:
//   VCLK           video clock
//   nRST           asynchronous active-low reset
//   nDSYNC         bus phase strobe, low during the sync phase
//   D_i[6:0]       multiplexed bus (sync bits in [3:0] during the sync phase)
//   vdata_valid_o  one-cycle strobe: new pixel vector on vdata_o
//   vdata_o[24:0]  {nVSYNC, nCLAMP, nHSYNC, nCSYNC, R[6:0], G[6:0], B[6:0]}
//   locked_o       cadence lock status
//   err_o          one-cycle pulse when lock is lost

module n64_vdemux #(
  parameter int unsigned LOCK_CNT = 8
) (
  input  logic        VCLK,
  input  logic        nRST,
  input  logic        nDSYNC,
  input  logic [6:0]  D_i,
  output logic        vdata_valid_o,
  output logic [24:0] vdata_o,
  output logic        locked_o,
  output logic        err_o
);

  // Last good-period count that still leaves the FSM in the check state.
  localparam logic [3:0] LockCntLast = 4'(LOCK_CNT - 1);

  typedef enum logic [1:0] {
    StUnlocked,
    StCheck,
    StLocked
  } state_e;

  // Registered bus.
  logic       nds_q;
  logic [6:0] d_q;

  // Cadence tracking and pixel assembly.
  logic [2:0] phase_q;
  logic [3:0] sync_tmp_q;
  logic [6:0] r_tmp_q;
  logic [6:0] g_tmp_q;

  // Lock FSM.
  state_e     state_q;
  logic [3:0] good_cnt_q;

  // Per-cycle cadence events.
  logic strobe;
  logic period_good;
  logic period_bad;

  always_comb begin
    // Blue is on the bus: the pixel is complete at this edge.
    strobe      = nds_q && (phase_q == 3'd2);
    // A sync phase exactly four cycles after the previous one.
    period_good = !nds_q && (phase_q == 3'd3);
    // Any other sync phase is a short, long or repeated strobe; a phase
    // about to saturate means the strobe went missing.
    period_bad  = (!nds_q && (phase_q != 3'd3)) || (nds_q && (phase_q == 3'd6));
  end

  // Input register, phase counter and component capture.
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      nds_q      <= 1'b1;
      d_q        <= 7'd0;
      phase_q    <= 3'd7;
      sync_tmp_q <= 4'd0;
      r_tmp_q    <= 7'd0;
      g_tmp_q    <= 7'd0;
    end else begin
      nds_q <= nDSYNC;
      d_q   <= D_i;
      if (!nds_q) begin
        phase_q    <= 3'd0;
        sync_tmp_q <= d_q[3:0];
      end else begin
        // Saturate so a missing strobe is flagged only once.
        if (phase_q != 3'd7) begin
          phase_q <= phase_q + 3'd1;
        end
        if (phase_q == 3'd0) begin
          r_tmp_q <= d_q;
        end
        if (phase_q == 3'd1) begin
          g_tmp_q <= d_q;
        end
      end
    end
  end

  // Lock FSM with registered outputs. The output vector is only written
  // when a strobe is released, so it holds between strobes and stays at
  // its last value while unlocked.
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= StUnlocked;
      good_cnt_q    <= 4'd0;
      locked_o      <= 1'b0;
      err_o         <= 1'b0;
      vdata_valid_o <= 1'b0;
      vdata_o       <= 25'd0;
    end else begin
      err_o         <= 1'b0;
      vdata_valid_o <= 1'b0;

      // The state is sampled before this edge's transition, and a bad event
      // at the same edge always wins over the strobe.
      if (strobe && (state_q == StLocked) && !period_bad) begin
        vdata_valid_o <= 1'b1;
        vdata_o       <= {sync_tmp_q, r_tmp_q, g_tmp_q, d_q};
      end

      unique case (state_q)
        StUnlocked: begin
          good_cnt_q <= 4'd0;
          locked_o   <= 1'b0;
          if (period_good) begin
            state_q    <= StCheck;
            good_cnt_q <= 4'd1;
          end
        end
        StCheck: begin
          if (period_bad) begin
            state_q    <= StUnlocked;
            good_cnt_q <= 4'd0;
          end else if (period_good) begin
            if (good_cnt_q == LockCntLast) begin
              state_q  <= StLocked;
              locked_o <= 1'b1;
            end else begin
              good_cnt_q <= good_cnt_q + 4'd1;
            end
          end
        end
        StLocked: begin
          if (period_bad) begin
            state_q    <= StUnlocked;
            good_cnt_q <= 4'd0;
            locked_o   <= 1'b0;
            err_o      <= 1'b1;
          end
        end
        default: begin
          state_q    <= StUnlocked;
          good_cnt_q <= 4'd0;
          locked_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_n64_vdemux.sv
// Testbench for n64_vdemux. Drives the bus pixel by pixel (clean, short,
// long, double-low and missing-strobe periods, plus an asynchronous reset)
// and compares every output on every cycle against a model that works from
// the history of sampled bus values: the distance between sync strobes
// decides good/bad periods, a run of good periods decides lock, and a pixel
// is released four samples after its sync strobe.

module tb_n64_vdemux;

  localparam int unsigned LockCnt = 8;
  localparam logic [24:0] CleanVec = {4'hA, 7'h11, 7'h22, 7'h33};

  logic        VCLK = 1'b0;
  logic        nRST = 1'b0;
  logic        nDSYNC = 1'b1;
  logic [6:0]  D_i = 7'd0;
  logic        vdata_valid_o;
  logic [24:0] vdata_o;
  logic        locked_o;
  logic        err_o;

  n64_vdemux #(
    .LOCK_CNT(LockCnt)
  ) dut (
    .VCLK         (VCLK),
    .nRST         (nRST),
    .nDSYNC       (nDSYNC),
    .D_i          (D_i),
    .vdata_valid_o(vdata_valid_o),
    .vdata_o      (vdata_o),
    .locked_o     (locked_o),
    .err_o        (err_o)
  );

  always #5 VCLK = ~VCLK;

  int checks = 0;
  int errors = 0;

  // Reference model: bus samples since reset, indexed by clock edge.
  logic        samp_nds[$];
  logic [6:0]  samp_d[$];
  int          edge_n;
  int          last_low;
  int          prev_low;
  int          streak;
  logic        m_locked;
  logic        m_valid;
  logic        m_err;
  logic [24:0] m_vdata;
  int          err_seen;

  task automatic check(input string tag, input logic [24:0] got, input logic [24:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    samp_nds.delete();
    samp_d.delete();
    edge_n   = 0;
    last_low = -100;
    prev_low = -100;
    streak   = 0;
    m_locked = 1'b0;
    m_valid  = 1'b0;
    m_err    = 1'b0;
    m_vdata  = 25'd0;
  endtask

  // Evaluate the clock edge edge_n from samples taken at earlier edges,
  // then record the sample taken at this edge.
  task automatic model_edge();
    logic low_now;
    logic good;
    logic bad;
    logic strobe;
    low_now = (edge_n >= 1) && (samp_nds[edge_n-1] == 1'b0);
    good    = 1'b0;
    bad     = 1'b0;
    strobe  = 1'b0;
    if (low_now) begin
      good = (prev_low == edge_n - 5);
      bad  = !good;
    end else begin
      bad    = (last_low >= 0) && ((edge_n - 1) - last_low == 7);
      strobe = (edge_n >= 4) && (last_low == edge_n - 4);
    end
    m_err   = m_locked && bad;
    m_valid = strobe && m_locked && !bad;
    if (m_valid) begin
      m_vdata = {samp_d[edge_n-4][3:0], samp_d[edge_n-3], samp_d[edge_n-2], samp_d[edge_n-1]};
    end
    if (bad) streak = 0;
    else if (good) streak++;
    m_locked = (streak >= LockCnt);
    samp_nds.push_back(nDSYNC);
    samp_d.push_back(D_i);
    if (!nDSYNC) begin
      prev_low = last_low;
      last_low = edge_n;
    end
    edge_n++;
  endtask

  task automatic cyc(input logic nds, input logic [6:0] d);
    @(negedge VCLK);
    nDSYNC = nds;
    D_i    = d;
    @(posedge VCLK);
    model_edge();
    #1;
    check("valid", 25'(vdata_valid_o), 25'(m_valid));
    check("err", 25'(err_o), 25'(m_err));
    check("locked", 25'(locked_o), 25'(m_locked));
    check("vdata", vdata_o, m_vdata);
    if (err_o) err_seen++;
  endtask

  task automatic pixel(input logic [3:0] s, input logic [6:0] r, input logic [6:0] g,
                       input logic [6:0] b);
    cyc(1'b0, {3'($urandom), s});
    cyc(1'b1, r);
    cyc(1'b1, g);
    cyc(1'b1, b);
  endtask

  task automatic pixel_rand();
    pixel(4'($urandom), 7'($urandom), 7'($urandom), 7'($urandom));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, 25'(vdata_valid_o), 25'd0);
    check({tag, "_err"}, 25'(err_o), 25'd0);
    check({tag, "_locked"}, 25'(locked_o), 25'd0);
    check({tag, "_vdata"}, vdata_o, 25'd0);
  endtask

  // Release reset just after a rising edge so the next edge is edge 0.
  task automatic release_reset();
    repeat (2) @(posedge VCLK);
    #2;
    nDSYNC = 1'b1;
    nRST   = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    err_seen = 0;
    #3;
    check_zero_outputs("reset");
    release_reset();

    // Clean stream: lock after LOCK_CNT+1 strobes, first valid 3 edges later.
    repeat (8) pixel(4'hA, 7'h11, 7'h22, 7'h33);
    cyc(1'b0, 7'h0A);
    check("lock_early", 25'(locked_o), 25'd0);
    cyc(1'b1, 7'h11);
    check("lock_time", 25'(locked_o), 25'd1);
    cyc(1'b1, 7'h22);
    cyc(1'b1, 7'h33);
    cyc(1'b0, 7'h7A);
    check("first_valid", 25'(vdata_valid_o), 25'd1);
    check("first_vec", vdata_o, CleanVec);
    cyc(1'b1, 7'h11);
    cyc(1'b1, 7'h22);
    cyc(1'b1, 7'h33);
    repeat (4) pixel(4'hA, 7'h11, 7'h22, 7'h33);

    // Latency: the pixel starting now is released after the fifth edge.
    pixel(4'h5, 7'h55, 7'h2A, 7'h01);
    cyc(1'b0, 7'h03);
    check("latency_valid", 25'(vdata_valid_o), 25'd1);
    check("latency_vec", vdata_o, {4'h5, 7'h55, 7'h2A, 7'h01});
    cyc(1'b1, 7'h10);
    cyc(1'b1, 7'h20);
    cyc(1'b1, 7'h30);

    // Short period: three cycles, then re-lock.
    repeat (3) pixel_rand();
    err_seen = 0;
    cyc(1'b0, 7'h0F);
    cyc(1'b1, 7'h44);
    cyc(1'b1, 7'h45);
    repeat (3) pixel_rand();
    check("short_err_once", 25'(err_seen), 25'd1);
    check("short_unlocked", 25'(locked_o), 25'd0);
    repeat (9) pixel_rand();
    check("short_relock", 25'(locked_o), 25'd1);

    // Missing strobe: bus stays in the colour phases.
    pixel_rand();
    err_seen = 0;
    repeat (10) cyc(1'b1, 7'($urandom));
    check("missing_err_once", 25'(err_seen), 25'd1);
    check("missing_unlocked", 25'(locked_o), 25'd0);

    // Double-low while in the check state.
    repeat (4) pixel_rand();
    cyc(1'b0, 7'($urandom));
    cyc(1'b0, 7'($urandom));
    cyc(1'b1, 7'($urandom));
    cyc(1'b1, 7'($urandom));
    cyc(1'b1, 7'($urandom));
    check("double_low_unlocked", 25'(locked_o), 25'd0);
    repeat (10) pixel_rand();

    // Asynchronous reset in the middle of a pixel.
    cyc(1'b0, 7'($urandom));
    cyc(1'b1, 7'($urandom));
    #2;
    nRST = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    release_reset();
    repeat (10) pixel_rand();

    // Random mix of clean pixels and cadence faults.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 13))
        10: begin
          cyc(1'b0, 7'($urandom));
          cyc(1'b1, 7'($urandom));
          cyc(1'b1, 7'($urandom));
        end
        11: begin
          pixel_rand();
          cyc(1'b1, 7'($urandom));
        end
        12: begin
          cyc(1'b0, 7'($urandom));
          pixel_rand();
        end
        13: begin
          repeat ($urandom_range(4, 12)) cyc(1'b1, 7'($urandom));
        end
        default: pixel_rand();
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
